// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for a shared, registered 8-to-1 selector mux.
// It drives a one-hot grant and the mux select, limits each owner's tenure, and tracks which source the mux output holds.
module mux_sel_arbiter #(
  parameter int NUM_REQ    = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int MAX_HOLD   = 4,
  parameter int HOLD_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] selector,
  output logic                 busy,
  output logic                 data_valid,
  output logic [SEL_WIDTH-1:0] data_src
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam logic [HOLD_WIDTH-1:0] CNT_MAX = HOLD_WIDTH'(MAX_HOLD - 1);

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_d;
  logic [SEL_WIDTH-1:0]   sel_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [HOLD_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     others;
  logic [NUM_REQ-1:0]     hand_req;
  logic [SEL_WIDTH-1:0]   winner;
  logic                   handover;

  // Scan for the first request set after the last owner, wrapping modulo NUM_REQ.
  function automatic logic [SEL_WIDTH-1:0] pick(input logic [NUM_REQ-1:0]   r,
                                                input logic [SEL_WIDTH-1:0] p);
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    pick  = p;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = p + SEL_WIDTH'(k);
      if (r[idx] && !found) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign others = req & ~(NUM_REQ'(1) << selector);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    grant_d  = grant;
    sel_d    = selector;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    handover = 1'b0;
    hand_req = req;
    winner   = '0;

    case (state_q)
      IDLE: begin
        if (|req) handover = 1'b1;
      end
      OWNED: begin
        if (!req[selector]) begin
          // A release takes priority over expiry. Hand over at the same edge so the mux never sits idle between owners.
          if (|req) begin
            handover = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q == CNT_MAX && |others) begin
          handover = 1'b1;
          hand_req = others;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + HOLD_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (handover) begin
      winner  = pick(hand_req, ptr_q);
      state_d = OWNED;
      grant_d = NUM_REQ'(1) << winner;
      sel_d   = winner;
      ptr_d   = winner;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant      <= '0;
      selector   <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_src   <= '0;
      cnt_q      <= '0;
      ptr_q      <= SEL_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      selector   <= sel_d;
      busy       <= |grant_d;
      data_valid <= busy;
      data_src   <= selector;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed testbench for mux_sel_arbiter.
// It covers reset, single-requester hold, tenure round-robin, release handover and reset in the middle of a tenure.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] selector;
  logic       busy;
  logic       data_valid;
  logic [2:0] data_src;

  int n_checks = 0;
  int n_fail   = 0;

  mux_sel_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .selector   (selector),
    .busy       (busy),
    .data_valid (data_valid),
    .data_src   (data_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge. The outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [7:0] exp_g;
  logic [2:0] exp_s, prev_s;

  initial begin
    rst = 1'b1;
    req = 8'h00;

    // Reset held for two cycles
    step();
    step();
    check("rst_grant", grant, 8'h00);
    check("rst_sel", {5'd0, selector}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_dv", {7'd0, data_valid}, 8'd0);
    check("rst_src", {5'd0, data_src}, 8'd0);

    // Single requester 0
    rst = 1'b0;
    req = 8'h01;
    step();
    check("t2_grant_c1", grant, 8'h01);
    check("t2_sel_c1", {5'd0, selector}, 8'd0);
    check("t2_busy_c1", {7'd0, busy}, 8'd1);
    check("t2_dv_c1", {7'd0, data_valid}, 8'd0);
    step();
    check("t2_dv_c2", {7'd0, data_valid}, 8'd1);
    check("t2_src_c2", {5'd0, data_src}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_hold", grant, 8'h01);
    end

    // Requesters 0 and 7 take turns, four cycles each
    do_reset();
    req    = 8'h81;
    prev_s = 3'd0;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_g = ((i / 4) % 2 == 0) ? 8'h01 : 8'h80;
      exp_s = ((i / 4) % 2 == 0) ? 3'd0 : 3'd7;
      check("t3_grant", grant, exp_g);
      check("t3_sel", {5'd0, selector}, {5'd0, exp_s});
      if (i > 0) begin
        check("t3_dv", {7'd0, data_valid}, 8'd1);
        check("t3_src", {5'd0, data_src}, {5'd0, prev_s});
      end
      prev_s = exp_s;
    end

    // Owner 2 releases while 3 and 5 wait: the grant moves to 3 at the same edge
    do_reset();
    req = 8'h04;
    step();
    check("t4_grant2", grant, 8'h04);
    req = 8'h2C;
    step();
    check("t4_still2", grant, 8'h04);
    req = 8'h28;
    step();
    check("t4_handover", grant, 8'h08);
    check("t4_sel3", {5'd0, selector}, 8'd3);
    check("t4_busy", {7'd0, busy}, 8'd1);

    // Owner 2 releases with no one waiting: the arbiter goes idle
    do_reset();
    req = 8'h04;
    step();
    step();
    req = 8'h00;
    step();
    check("t4_idle_grant", grant, 8'h00);
    check("t4_idle_sel", {5'd0, selector}, 8'd2);
    check("t4_idle_busy", {7'd0, busy}, 8'd0);
    check("t4_idle_dv_hi", {7'd0, data_valid}, 8'd1);
    check("t4_idle_src", {5'd0, data_src}, 8'd2);
    step();
    check("t4_idle_dv_lo", {7'd0, data_valid}, 8'd0);

    // All eight requesting: grants rotate 0..7 then 0, four cycles each
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 36; i++) begin
      step();
      exp_s = 3'((i / 4) % 8);
      exp_g = 8'h01 << exp_s;
      check("t5_grant", grant, exp_g);
      check("t5_sel", {5'd0, selector}, {5'd0, exp_s});
    end

    // Reset in the middle of owner 5's tenure
    do_reset();
    req = 8'h20;
    step();
    check("t6_grant5", grant, 8'h20);
    step();
    rst = 1'b1;
    step();
    check("t6_rst_grant", grant, 8'h00);
    check("t6_rst_sel", {5'd0, selector}, 8'd0);
    check("t6_rst_busy", {7'd0, busy}, 8'd0);
    check("t6_rst_dv", {7'd0, data_valid}, 8'd0);
    rst = 1'b0;
    step();
    check("t6_regrant5", grant, 8'h20);
    check("t6_regrant_sel", {5'd0, selector}, 8'd5);
    step();
    req = 8'h21;
    rst = 1'b1;
    step();
    check("t6b_rst_grant", grant, 8'h00);
    rst = 1'b0;
    step();
    check("t6b_first0", grant, 8'h01);
    check("t6b_sel0", {5'd0, selector}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
